alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parameterised, registered arithmetic/logic unit; operands OPA/OPB, per-operand valid qualifiers, clock enable.
- MODE selects arithmetic (1) or logical (0) command set, decoded from CMD.
- Drives result, carry, overflow, compare flags and error.
- Sits behind the alu_inf interface as the verification DUT; standalone, no submodule dependencies.

Parameters:
- N, 8, operand width in bits.
- CMD_W, 4, command field width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; when 0 all outputs hold.
- MODE  in  1  1 = arithmetic, 0 = logical.
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
- CMD  in  CMD_W  operation code.
- OPA  in  N  operand A.
- OPB  in  N  operand B.
- CIN  in  1  carry-in for ADD_CIN/SUB_CIN.
- RES  out  2N  result, zero-extended.
- COUT  out  1  carry out.
- OFLOW  out  1  subtract borrow / signed overflow.
- G, E, L  out  1 each  compare flags A>B, A==B, A<B.
- ERR  out  1  illegal command or missing operand.

Behaviour:
- Reset (RST=0, async): RES=0; COUT, OFLOW, G, E, L, ERR all 0; multiply pipeline cleared.
- CE=1: inputs sampled at each rising edge; outputs registered, valid 1 cycle later.
- CE=0: no sampling; outputs and the multiply stage hold.
- Each accepted op first clears every flag, then sets only the flags that op defines.
- Arithmetic (MODE=1), required INP_VALID in brackets:
  - 0 ADD: A+B [11]; COUT = bit N.
  - 1 SUB: A-B [11]; OFLOW = 1 when A<B; RES = low N bits of the wrapped difference.
  - 2 ADD_CIN: A+B+CIN [11]; COUT set.
  - 3 SUB_CIN: A-B-CIN [11]; OFLOW = borrow.
  - 4 INC_A: A+1 [x1].
  - 5 DEC_A: A-1 [x1].
  - 6 INC_B: B+1 [1x].
  - 7 DEC_B: B-1 [1x].
  - 4–7 wrap at N bits: RES[N] = carry for INC, RES = 2^N-1 after DEC of 0, OFLOW = 1 on DEC of 0.
  - 8 CMP [11]: exactly one of G/E/L set; RES=0.
  - 9 MUL_INC: (A+1)*(B+1) [11].
  - 10 MUL_SHL: ((A<<1) mod 2^N)*B [11].
  - 9–10 have latency 2 (one internal stage); the intermediate cycle holds the previous outputs.
- Logical (MODE=0), result in RES[N-1:0], upper bits 0:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR [11].
  - 6 NOT_A [x1]; 7 NOT_B [1x].
  - 8 SHR1_A, 9 SHL1_A [x1]; 10 SHR1_B, 11 SHL1_B [1x].
  - 12 ROL_A_B, 13 ROR_A_B [11]: A rotated by OPB[log2(N)-1:0]; ERR=1 when any OPB bit above that field is set, result still produced.
- Error: ERR=1, RES=0, other flags 0 when:
  - CMD is unused (arith >10, logical >13);
  - INP_VALID lacks a required operand (00 is always an error).
- Command changes during a multiply: the multiply completes; the new op's result follows in order.
- Reset mid-multiply aborts it.

Decomposition:
- Shared package alu_pkg: N, CMD_W, arithmetic and logical command enums, INP_VALID encoding constants.
- One natural submodule, alu_mul_stage: 2-cycle multiply path with its CE-gated register.
- All other logic is a combinational decoder feeding one output register.

Test Plan:
- Reset: RST=0 asserted mid-operation -> all outputs 0 immediately; first op after release gives correct result at +1 cycle.
- ADD, N=8: OPA=0xFF, OPB=0x01, MODE=1, CMD=0, INP_VALID=11 -> RES=0x100, COUT=1 next cycle.
- SUB: OPA=0x05, OPB=0x0A, MODE=1, CMD=1 -> OFLOW=1, RES=0xFB.
- CMP: OPA=0x10, OPB=0x10 -> E=1, G=0, L=0.
- CMP: OPA=0x20, OPB=0x10 -> G=1, E=0, L=0.
- MUL_INC: OPA=3, OPB=4, CMD=9 -> RES=20 exactly 2 cycles later.
- MUL_SHL: OPA=3, OPB=5, CMD=10 -> RES=30.
- Logical and error cases:
  - ROL: MODE=0, CMD=12, OPA=0x81, OPB=0x01 -> RES=0x03, ERR=0.
  - ROL with OPB=0x10 -> ERR=1.
  - CMD=15, MODE=0 -> ERR=1, RES=0.
  - ADD with INP_VALID=01 -> ERR=1.
  - CE=0 for 3 cycles with changing inputs -> outputs unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, command encodings and flag bundle for the registered ALU.
package alu_pkg;

  localparam int ALU_N     = 8;
  localparam int ALU_CMD_W = 4;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  localparam logic [1:0] VALID_NONE = 2'b00;
  localparam logic [1:0] VALID_A    = 2'b01;
  localparam logic [1:0] VALID_B    = 2'b10;
  localparam logic [1:0] VALID_AB   = 2'b11;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic e;
    logic l;
    logic err;
  } alu_flags_t;

  function automatic logic has_operands(input logic [1:0] inp_valid, input logic [1:0] need);
    return (inp_valid & need) == need;
  endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// Two-cycle multiply path: operands are captured on accept, product is formed from the captured copy.
module alu_mul_stage
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           load,
  input  logic           shl_sel,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic [2*N-1:0] product
);

  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         shl_q;
  logic [N:0]   a_inc;
  logic [N:0]   b_inc;
  logic [N-1:0] a_shl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      shl_q <= 1'b0;
    end else if (ce) begin
      busy <= load;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        shl_q <= shl_sel;
      end
    end
  end

  // Products wrap at 2N bits, so (2^N)*(2^N) for MUL_INC reads back as zero.
  always_comb begin
    a_inc   = {1'b0, a_q} + {{N{1'b0}}, 1'b1};
    b_inc   = {1'b0, b_q} + {{N{1'b0}}, 1'b1};
    a_shl   = a_q << 1;
    product = shl_q ? ({{N{1'b0}}, a_shl} * {{N{1'b0}}, b_q})
                    : ({{(N-1){1'b0}}, a_inc} * {{(N-1){1'b0}}, b_inc});
  end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: combinational decode into one output register, with a one-entry in-order
// holding slot so results following a multiply leave in issue order.
module alu_unit
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int CMD_W = ALU_CMD_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             MODE,
  input  logic [1:0]       INP_VALID,
  input  logic [CMD_W-1:0] CMD,
  input  logic [N-1:0]     OPA,
  input  logic [N-1:0]     OPB,
  input  logic             CIN,
  output logic [2*N-1:0]   RES,
  output logic             COUT,
  output logic             OFLOW,
  output logic             G,
  output logic             E,
  output logic             L,
  output logic             ERR
);

  localparam int             LOG_N = $clog2(N);
  localparam logic [LOG_N:0] N_AMT = (LOG_N+1)'(N);

  logic [N:0]     sum_ab, sum_cin, diff_ab, diff_cin, inc_a, inc_b;
  logic [N-1:0]   dec_a, dec_b, rol_a, ror_a;
  logic [LOG_N:0] amt;
  logic           amt_err;

  logic [2*N-1:0] cur_res;
  alu_flags_t     cur_f;
  logic           is_mul;
  logic           legal;
  logic [1:0]     need;

  logic           mul_busy;
  logic [2*N-1:0] mul_product;
  logic           pend_valid;
  logic [2*N-1:0] pend_res;
  alu_flags_t     pend_f;
  logic [2*N-1:0] out_res;
  alu_flags_t     out_f;
  logic           occupied;

  // Carry and borrow come from the extra top bit of each N+1-bit sum/difference.
  always_comb begin
    sum_ab   = {1'b0, OPA} + {1'b0, OPB};
    sum_cin  = sum_ab + {{N{1'b0}}, CIN};
    diff_ab  = {1'b0, OPA} - {1'b0, OPB};
    diff_cin = diff_ab - {{N{1'b0}}, CIN};
    inc_a    = {1'b0, OPA} + {{N{1'b0}}, 1'b1};
    inc_b    = {1'b0, OPB} + {{N{1'b0}}, 1'b1};
    dec_a    = OPA - {{(N-1){1'b0}}, 1'b1};
    dec_b    = OPB - {{(N-1){1'b0}}, 1'b1};
    amt      = {1'b0, OPB[LOG_N-1:0]};
    amt_err  = |(OPB >> LOG_N);
    rol_a    = (OPA << amt) | (OPA >> (N_AMT - amt));
    ror_a    = (OPA >> amt) | (OPA << (N_AMT - amt));
  end

  always_comb begin
    cur_res = '0;
    cur_f   = '0;
    is_mul  = 1'b0;
    legal   = 1'b1;
    need    = VALID_AB;
    if (MODE) begin
      case (CMD)
        A_ADD:     begin cur_res = {{(N-1){1'b0}}, sum_ab};  cur_f.cout = sum_ab[N]; end
        A_SUB:     begin cur_res = {{N{1'b0}}, diff_ab[N-1:0]};  cur_f.oflow = diff_ab[N]; end
        A_ADD_CIN: begin cur_res = {{(N-1){1'b0}}, sum_cin}; cur_f.cout = sum_cin[N]; end
        A_SUB_CIN: begin cur_res = {{N{1'b0}}, diff_cin[N-1:0]}; cur_f.oflow = diff_cin[N]; end
        A_INC_A:   begin need = VALID_A; cur_res = {{(N-1){1'b0}}, inc_a}; end
        A_DEC_A:   begin need = VALID_A; cur_res = {{N{1'b0}}, dec_a}; cur_f.oflow = (OPA == '0); end
        A_INC_B:   begin need = VALID_B; cur_res = {{(N-1){1'b0}}, inc_b}; end
        A_DEC_B:   begin need = VALID_B; cur_res = {{N{1'b0}}, dec_b}; cur_f.oflow = (OPB == '0); end
        A_CMP: begin
          cur_f.g = OPA > OPB;
          cur_f.e = OPA == OPB;
          cur_f.l = OPA < OPB;
        end
        A_MUL_INC, A_MUL_SHL: is_mul = 1'b1;
        default: legal = 1'b0;
      endcase
    end else begin
      case (CMD)
        L_AND:     cur_res = {{N{1'b0}}, OPA & OPB};
        L_NAND:    cur_res = {{N{1'b0}}, ~(OPA & OPB)};
        L_OR:      cur_res = {{N{1'b0}}, OPA | OPB};
        L_NOR:     cur_res = {{N{1'b0}}, ~(OPA | OPB)};
        L_XOR:     cur_res = {{N{1'b0}}, OPA ^ OPB};
        L_XNOR:    cur_res = {{N{1'b0}}, ~(OPA ^ OPB)};
        L_NOT_A:   begin need = VALID_A; cur_res = {{N{1'b0}}, ~OPA}; end
        L_NOT_B:   begin need = VALID_B; cur_res = {{N{1'b0}}, ~OPB}; end
        L_SHR1_A:  begin need = VALID_A; cur_res = {{N{1'b0}}, OPA >> 1}; end
        L_SHL1_A:  begin need = VALID_A; cur_res = {{N{1'b0}}, OPA << 1}; end
        L_SHR1_B:  begin need = VALID_B; cur_res = {{N{1'b0}}, OPB >> 1}; end
        L_SHL1_B:  begin need = VALID_B; cur_res = {{N{1'b0}}, OPB << 1}; end
        L_ROL_A_B: begin cur_res = {{N{1'b0}}, rol_a}; cur_f.err = amt_err; end
        L_ROR_A_B: begin cur_res = {{N{1'b0}}, ror_a}; cur_f.err = amt_err; end
        default:   legal = 1'b0;
      endcase
    end
    // Illegal commands and missing operands override everything, including a multiply launch.
    if (!legal || !has_operands(INP_VALID, need)) begin
      cur_res   = '0;
      cur_f     = '0;
      cur_f.err = 1'b1;
      is_mul    = 1'b0;
    end
  end

  alu_mul_stage #(.N(N)) u_mul (
    .clk     (CLK),
    .rst_n   (RST),
    .ce      (CE),
    .load    (is_mul),
    .shl_sel (CMD == A_MUL_SHL),
    .a       (OPA),
    .b       (OPB),
    .busy    (mul_busy),
    .product (mul_product)
  );

  assign occupied = mul_busy | pend_valid;

  // Once a multiply has opened a slot, every later op drains through that slot to keep order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_res    <= '0;
      out_f      <= '0;
      pend_valid <= 1'b0;
      pend_res   <= '0;
      pend_f     <= '0;
    end else if (CE) begin
      if (occupied) begin
        out_res <= mul_busy ? mul_product : pend_res;
        out_f   <= mul_busy ? '0 : pend_f;
      end else if (!is_mul) begin
        out_res <= cur_res;
        out_f   <= cur_f;
      end
      pend_valid <= occupied & ~is_mul;
      pend_res   <= cur_res;
      pend_f     <= cur_f;
    end
  end

  assign RES   = out_res;
  assign COUT  = out_f.cout;
  assign OFLOW = out_f.oflow;
  assign G     = out_f.g;
  assign E     = out_f.e;
  assign L     = out_f.l;
  assign ERR   = out_f.err;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed steps then random ops against an arithmetic reference model.
module tb_alu_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CE = 1'b0;
  logic        MODE = 1'b0;
  logic [1:0]  INP_VALID = 2'b00;
  logic [3:0]  CMD = 4'd0;
  logic [7:0]  OPA = 8'd0;
  logic [7:0]  OPB = 8'd0;
  logic        CIN = 1'b0;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, E, L, ERR;

  alu_unit dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .INP_VALID(INP_VALID),
    .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          write_at;
    logic [15:0] res;
    logic [5:0]  flags;
  } sched_t;

  sched_t      sched[$];
  int          edge_no = 0;
  int          last_write = -100;
  int          assert_count = 0;
  int          fail_count = 0;
  logic [15:0] exp_res = '0;
  logic [5:0]  exp_flags = '0;

  // Reference result of one op; flags packed as {cout, oflow, g, e, l, err}.
  function automatic void refOp(input bit mode, input logic [1:0] iv, input int cmd,
                                input int a, input int b, input int cin,
                                output logic [15:0] res, output logic [5:0] flags, output bit mul);
    int r = 0;
    int need = 3;
    int k;
    bit cout = 0, ofl = 0, g = 0, e = 0, l = 0, err = 0, legal = 1;
    mul = 0;
    if (mode) begin
      case (cmd)
        0: begin r = a + b; cout = (r > 255); end
        1: begin r = (a - b) & 255; ofl = (a < b); end
        2: begin r = a + b + cin; cout = (r > 255); end
        3: begin r = (a - b - cin) & 255; ofl = (a < b + cin); end
        4: begin need = 1; r = a + 1; end
        5: begin need = 1; r = (a + 255) & 255; ofl = (a == 0); end
        6: begin need = 2; r = b + 1; end
        7: begin need = 2; r = (b + 255) & 255; ofl = (b == 0); end
        8: begin g = (a > b); e = (a == b); l = (a < b); end
        9: begin r = ((a + 1) * (b + 1)) & 65535; mul = 1; end
        10: begin r = ((a * 2) & 255) * b; mul = 1; end
        default: legal = 0;
      endcase
    end else begin
      k = b % 8;
      case (cmd)
        0: r = a & b;
        1: r = ~(a & b) & 255;
        2: r = a | b;
        3: r = ~(a | b) & 255;
        4: r = a ^ b;
        5: r = ~(a ^ b) & 255;
        6: begin need = 1; r = ~a & 255; end
        7: begin need = 2; r = ~b & 255; end
        8: begin need = 1; r = a / 2; end
        9: begin need = 1; r = (a * 2) & 255; end
        10: begin need = 2; r = b / 2; end
        11: begin need = 2; r = (b * 2) & 255; end
        12: begin r = ((a << k) | (a >> (8 - k))) & 255; err = (b > 7); end
        13: begin r = ((a >> k) | (a << (8 - k))) & 255; err = (b > 7); end
        default: legal = 0;
      endcase
    end
    if (!legal || ((int'(iv) & need) != need)) begin
      r = 0; cout = 0; ofl = 0; g = 0; e = 0; l = 0; err = 1; mul = 0;
    end
    res   = r[15:0];
    flags = {cout, ofl, g, e, l, err};
  endfunction

  task automatic checkOutput(input string tag);
    assert_count++;
    assert ({RES, COUT, OFLOW, G, E, L, ERR} === {exp_res, exp_flags})
    else begin
      fail_count++;
      $error("[TB] FAIL %s: got RES=%h flags=%b, expected RES=%h flags=%b",
             tag, RES, {COUT, OFLOW, G, E, L, ERR}, exp_res, exp_flags);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issue latency is one edge, two for a multiply, and results never overtake each other.
  task automatic applyStimulus(input bit ce, input bit mode, input logic [1:0] iv, input int cmd,
                               input int a, input int b, input int cin, input string tag);
    logic [15:0] r;
    logic [5:0]  f;
    bit          mul;
    int          w;
    sched_t      s;
    CE = ce; MODE = mode; INP_VALID = iv; CMD = cmd[3:0];
    OPA = a[7:0]; OPB = b[7:0]; CIN = cin[0];
    @(posedge CLK);
    #1;
    if (ce) begin
      refOp(mode, iv, cmd & 15, a & 255, b & 255, cin & 1, r, f, mul);
      w = edge_no + (mul ? 1 : 0);
      if (w < last_write + 1) w = last_write + 1;
      last_write = w;
      s.write_at = w; s.res = r; s.flags = f;
      sched.push_back(s);
      if (sched.size() > 0 && sched[0].write_at == edge_no) begin
        s = sched.pop_front();
        exp_res   = s.res;
        exp_flags = s.flags;
      end
      edge_no++;
    end
    checkOutput(tag);
  endtask

  task automatic doReset();
    RST = 1'b0;
    #2;
    sched.delete();
    last_write = -100;
    exp_res   = '0;
    exp_flags = '0;
    checkOutput("async_reset");
    #2;
    RST = 1'b1;
  endtask

  initial begin
    #12;
    checkOutput("reset_state");
    RST = 1'b1;

    applyStimulus(1, 1, 2'b11, 0, 'hFF, 'h01, 0, "add_ff_01");
    checkValue("add_res", RES, 16'h0100);
    checkValue("add_cout", {15'd0, COUT}, 16'd1);
    applyStimulus(1, 1, 2'b11, 1, 'h05, 'h0A, 0, "sub_borrow");
    checkValue("sub_res", RES, 16'h00FB);
    checkValue("sub_oflow", {15'd0, OFLOW}, 16'd1);
    applyStimulus(1, 1, 2'b11, 8, 'h10, 'h10, 0, "cmp_eq");
    checkValue("cmp_eq_gel", {13'd0, G, E, L}, 16'b010);
    applyStimulus(1, 1, 2'b11, 8, 'h20, 'h10, 0, "cmp_gt");
    checkValue("cmp_gt_gel", {13'd0, G, E, L}, 16'b100);

    applyStimulus(1, 1, 2'b11, 9, 3, 4, 0, "mul_inc_issue");
    checkValue("mul_inc_hold", {13'd0, G, E, L}, 16'b100);
    applyStimulus(1, 1, 2'b11, 10, 3, 5, 0, "mul_shl_issue");
    checkValue("mul_inc_res", RES, 16'd20);
    applyStimulus(1, 1, 2'b11, 0, 1, 2, 0, "add_after_mul");
    checkValue("mul_shl_res", RES, 16'd30);
    doReset();

    applyStimulus(1, 0, 2'b11, 12, 'h81, 'h01, 0, "rol_first_after_reset");
    checkValue("rol_res", RES, 16'h0003);
    checkValue("rol_err", {15'd0, ERR}, 16'd0);
    applyStimulus(1, 0, 2'b11, 12, 'h81, 'h10, 0, "rol_range_err");
    checkValue("rol_range_err_flag", {15'd0, ERR}, 16'd1);
    applyStimulus(1, 0, 2'b11, 15, 'h12, 'h34, 0, "illegal_cmd");
    checkValue("illegal_err", {15'd0, ERR}, 16'd1);
    checkValue("illegal_res", RES, 16'd0);
    applyStimulus(1, 1, 2'b11, 5, 0, 0, 0, "dec_a_zero");
    applyStimulus(1, 1, 2'b10, 4, 'hFF, 0, 0, "inc_a_missing_a");
    applyStimulus(1, 1, 2'b01, 0, 'h12, 'h34, 0, "add_missing_b");
    checkValue("add_missing_b_err", {15'd0, ERR}, 16'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 2'b11, i, $urandom_range(0, 255), $urandom_range(0, 255), 1, "ce_low_hold");
    applyStimulus(1, 1, 2'b11, 9, 'hFF, 'hFF, 0, "mul_inc_wrap");
    applyStimulus(0, 0, 2'b11, 0, 1, 1, 0, "mul_ce_low");
    applyStimulus(1, 0, 2'b11, 0, 'hF0, 'h3C, 0, "and_after_mul");
    doReset();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
                    $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 1), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
